// File: rtl/instr_register_pipe.sv
// ---------------------------------------------------------------------------
// instr_register_pipe
//
// Purpose: DEPTH-entry instruction register. Each accepted instruction
// (opcode, operand_a, operand_b) is executed and stored together with its
// result, a divide-error flag and a written flag. Single-cycle ops pass
// through a one-stage execute pipeline. DIV/MOD use an iterative restoring
// divider that holds load_ready low while it runs. The read port is
// registered.
//
// Ports:
//   clk            clock
//   reset          synchronous, active-high reset
//   load_en        write request (valid)
//   load_ready     block can accept (low while the divider is busy or in reset)
//   opcode         operation to perform
//   operand_a/b    signed operands
//   write_pointer  destination entry (ignored when AUTO_WP = 1)
//   read_en        read request
//   read_pointer   entry to read
//   rd_valid       rd_* outputs were loaded by the previous edge
//   rd_opcode      stored opcode
//   rd_operand_a/b stored operands
//   rd_result      stored result
//   rd_div_err     entry was a DIV/MOD by zero
//   rd_written     entry written since reset
// ---------------------------------------------------------------------------

package instr_register_pipe_pkg;
  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;
endpackage

// Divider control states
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   DIV_IDLE | no divide in flight, load_ready follows reset only
//   DIV_RUN  | one quotient bit per cycle, iteration counter counts down
//   DIV_DONE | sign-correct and write the entry, release load_ready
module instr_register_pipe
  import instr_register_pipe_pkg::*;
#(
  parameter int OP_WIDTH = 32,
  parameter int DEPTH    = 32,
  parameter int AUTO_WP  = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load_en,
  output logic                        load_ready,
  input  opcode_t                     opcode,
  input  logic signed [OP_WIDTH-1:0]  operand_a,
  input  logic signed [OP_WIDTH-1:0]  operand_b,
  input  logic [$clog2(DEPTH)-1:0]    write_pointer,
  input  logic                        read_en,
  input  logic [$clog2(DEPTH)-1:0]    read_pointer,
  output logic                        rd_valid,
  output opcode_t                     rd_opcode,
  output logic signed [OP_WIDTH-1:0]  rd_operand_a,
  output logic signed [OP_WIDTH-1:0]  rd_operand_b,
  output logic signed [OP_WIDTH-1:0]  rd_result,
  output logic                        rd_div_err,
  output logic                        rd_written
);

  localparam int AW = $clog2(DEPTH);
  localparam int W  = OP_WIDTH;
  localparam int CW = $clog2(OP_WIDTH + 1);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // ---------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------
  div_state_t div_state, div_state_n;
  logic       div_busy;
  logic       accept;
  logic       is_div_op;
  logic       div_start;
  logic       single_start;

  assign div_busy     = (div_state != DIV_IDLE);
  assign load_ready   = !reset && !div_busy;
  assign accept       = load_en && load_ready;
  assign is_div_op    = (opcode == DIV) || (opcode == MOD);
  assign div_start    = accept && is_div_op;
  assign single_start = accept && !is_div_op;

  // ---------------------------------------------------------------------
  // Write pointer selection
  // ---------------------------------------------------------------------
  logic [AW-1:0] wp_int;
  logic [AW-1:0] dest_ptr;

  assign dest_ptr = (AUTO_WP != 0) ? wp_int : write_pointer;

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_int <= '0;
    end else if (accept) begin
      wp_int <= wp_int + AW'(1);   // wraps DEPTH-1 -> 0 because DEPTH is 2**AW
    end
  end

  // ---------------------------------------------------------------------
  // Single-cycle execute stage
  // ---------------------------------------------------------------------
  logic                stage_valid;
  opcode_t             s_opc;
  logic signed [W-1:0] s_a;
  logic signed [W-1:0] s_b;
  logic [AW-1:0]       s_ptr;
  logic signed [W-1:0] alu_res;

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_valid <= 1'b0;
      s_opc       <= ZERO;
      s_a         <= '0;
      s_b         <= '0;
      s_ptr       <= '0;
    end else begin
      stage_valid <= single_start;
      if (single_start) begin
        s_opc <= opcode;
        s_a   <= operand_a;
        s_b   <= operand_b;
        s_ptr <= dest_ptr;
      end
    end
  end

  // ADD/SUB/MULT keep only the low W bits of the true result.
  always_comb begin
    alu_res = '0;
    case (s_opc)
      ZERO:    alu_res = '0;
      PASSA:   alu_res = s_a;
      PASSB:   alu_res = s_b;
      ADD:     alu_res = s_a + s_b;
      SUB:     alu_res = s_a - s_b;
      MULT:    alu_res = s_a * s_b;
      default: alu_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Iterative divider
  // ---------------------------------------------------------------------
  // Works on magnitudes. |MIN_INT| = 2**(W-1) still fits in W unsigned
  // bits, so MIN_INT / -1 falls out naturally as quotient 2**(W-1), whose
  // bit pattern is MIN_INT again.
  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    return v[W-1] ? (~v + W'(1)) : v;
  endfunction

  logic [W-1:0]        dq;        // dividend shifting out, quotient shifting in
  logic [W-1:0]        dvs;
  logic [W-1:0]        rem;
  logic [CW-1:0]       div_cnt;
  logic                neg_q;
  logic                neg_r;
  logic                zero_div;
  opcode_t             d_opc;
  logic signed [W-1:0] d_a;
  logic signed [W-1:0] d_b;
  logic [AW-1:0]       d_ptr;

  logic [W:0]          rem_sh;
  logic [W:0]          rem_sub;
  logic                rem_ge;
  logic [W-1:0]        rem_next;
  logic [W-1:0]        dq_next;
  logic                div_last;
  logic [W-1:0]        q_fix;
  logic [W-1:0]        r_fix;
  logic signed [W-1:0] div_res;

  assign rem_sh   = {rem, dq[W-1]};
  assign rem_sub  = rem_sh - {1'b0, dvs};
  assign rem_ge   = (rem_sh >= {1'b0, dvs});
  assign rem_next = rem_ge ? rem_sub[W-1:0] : rem_sh[W-1:0];
  assign dq_next  = {dq[W-2:0], rem_ge};
  assign div_last = (div_cnt == CW'(1));

  // Quotient truncates toward zero; remainder takes the dividend's sign.
  assign q_fix   = neg_q ? (~dq + W'(1)) : dq;
  assign r_fix   = neg_r ? (~rem + W'(1)) : rem;
  assign div_res = zero_div ? '0 : ((d_opc == DIV) ? q_fix : r_fix);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_state <= DIV_IDLE;
    end else begin
      div_state <= div_state_n;
    end
  end

  always_comb begin
    div_state_n = div_state;
    case (div_state)
      DIV_IDLE: if (div_start) div_state_n = DIV_RUN;
      DIV_RUN:  if (div_last)  div_state_n = DIV_DONE;
      DIV_DONE: div_state_n = DIV_IDLE;
      default:  div_state_n = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dq       <= '0;
      dvs      <= '0;
      rem      <= '0;
      div_cnt  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      zero_div <= 1'b0;
      d_opc    <= ZERO;
      d_a      <= '0;
      d_b      <= '0;
      d_ptr    <= '0;
    end else if (div_start) begin
      dq       <= mag(operand_a);
      dvs      <= mag(operand_b);
      rem      <= '0;
      div_cnt  <= CW'(OP_WIDTH);
      neg_q    <= operand_a[W-1] ^ operand_b[W-1];
      neg_r    <= operand_a[W-1];
      zero_div <= (operand_b == '0);
      d_opc    <= opcode;
      d_a      <= operand_a;
      d_b      <= operand_b;
      d_ptr    <= dest_ptr;
    end else if (div_state == DIV_RUN) begin
      dq      <= dq_next;
      rem     <= rem_next;
      div_cnt <= div_cnt - CW'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Entry write port
  // ---------------------------------------------------------------------
  // The divider finishes at least one edge after any single-cycle op that
  // was in the stage when it started, and no new op is accepted while it
  // runs, so the two sources never request the same edge.
  logic                wr_en;
  logic [AW-1:0]       wr_ptr;
  opcode_t             wr_opc;
  logic signed [W-1:0] wr_a;
  logic signed [W-1:0] wr_b;
  logic signed [W-1:0] wr_res;
  logic                wr_err;

  always_comb begin
    wr_en  = 1'b0;
    wr_ptr = '0;
    wr_opc = ZERO;
    wr_a   = '0;
    wr_b   = '0;
    wr_res = '0;
    wr_err = 1'b0;
    if (div_state == DIV_DONE) begin
      wr_en  = 1'b1;
      wr_ptr = d_ptr;
      wr_opc = d_opc;
      wr_a   = d_a;
      wr_b   = d_b;
      wr_res = div_res;
      wr_err = zero_div;
    end else if (stage_valid) begin
      wr_en  = 1'b1;
      wr_ptr = s_ptr;
      wr_opc = s_opc;
      wr_a   = s_a;
      wr_b   = s_b;
      wr_res = alu_res;
      wr_err = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Entry storage
  // ---------------------------------------------------------------------
  opcode_t             mem_opc [DEPTH];
  logic signed [W-1:0] mem_a   [DEPTH];
  logic signed [W-1:0] mem_b   [DEPTH];
  logic signed [W-1:0] mem_res [DEPTH];
  logic                mem_err [DEPTH];
  logic                mem_wr  [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_opc[i] <= ZERO;
        mem_a[i]   <= '0;
        mem_b[i]   <= '0;
        mem_res[i] <= '0;
        mem_err[i] <= 1'b0;
        mem_wr[i]  <= 1'b0;
      end
    end else if (wr_en) begin
      mem_opc[wr_ptr] <= wr_opc;
      mem_a[wr_ptr]   <= wr_a;
      mem_b[wr_ptr]   <= wr_b;
      mem_res[wr_ptr] <= wr_res;
      mem_err[wr_ptr] <= wr_err;
      mem_wr[wr_ptr]  <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Registered read port
  // ---------------------------------------------------------------------
  // Reads sample the array before this edge's write lands, so a same-edge
  // read of the entry being written returns its old contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid     <= 1'b0;
      rd_opcode    <= ZERO;
      rd_operand_a <= '0;
      rd_operand_b <= '0;
      rd_result    <= '0;
      rd_div_err   <= 1'b0;
      rd_written   <= 1'b0;
    end else begin
      rd_valid <= read_en;
      if (read_en) begin
        rd_opcode    <= mem_opc[read_pointer];
        rd_operand_a <= mem_a[read_pointer];
        rd_operand_b <= mem_b[read_pointer];
        rd_result    <= mem_res[read_pointer];
        rd_div_err   <= mem_err[read_pointer];
        rd_written   <= mem_wr[read_pointer];
      end
    end
  end

endmodule

// File: tb/tb_instr_register_pipe.sv
// ---------------------------------------------------------------------------
// tb_instr_register_pipe
//
// Drives two instances from the same stimulus: one addressed through
// write_pointer (AUTO_WP=0) and one with the internal auto pointer
// (AUTO_WP=1). A reference model holds the expected contents of both
// arrays and computes results with plain 64-bit arithmetic.
// ---------------------------------------------------------------------------
module tb_instr_register_pipe;
  import instr_register_pipe_pkg::*;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_en;
  logic          read_en;
  opcode_t       opcode;
  logic [W-1:0]  operand_a;
  logic [W-1:0]  operand_b;
  logic [AW-1:0] write_pointer;
  logic [AW-1:0] read_pointer;

  logic          ready0, ready1;
  logic          v0, v1;
  opcode_t       ro0, ro1;
  logic [W-1:0]  ra0, rb0, rr0, ra1, rb1, rr1;
  logic          re0, re1, rw0, rw1;

  always #5 clk = ~clk;

  instr_register_pipe #(.OP_WIDTH(W), .DEPTH(D), .AUTO_WP(0)) dut0 (
    .clk(clk), .reset(reset), .load_en(load_en), .load_ready(ready0),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .write_pointer(write_pointer), .read_en(read_en), .read_pointer(read_pointer),
    .rd_valid(v0), .rd_opcode(ro0), .rd_operand_a(ra0), .rd_operand_b(rb0),
    .rd_result(rr0), .rd_div_err(re0), .rd_written(rw0)
  );

  instr_register_pipe #(.OP_WIDTH(W), .DEPTH(D), .AUTO_WP(1)) dut1 (
    .clk(clk), .reset(reset), .load_en(load_en), .load_ready(ready1),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .write_pointer(write_pointer), .read_en(read_en), .read_pointer(read_pointer),
    .rd_valid(v1), .rd_opcode(ro1), .rd_operand_a(ra1), .rd_operand_b(rb1),
    .rd_result(rr1), .rd_div_err(re1), .rd_written(rw1)
  );

  // reference model: [0] = write_pointer instance, [1] = auto-pointer instance
  opcode_t      m_opc [2][D];
  logic [W-1:0] m_a   [2][D];
  logic [W-1:0] m_b   [2][D];
  logic [W-1:0] m_r   [2][D];
  logic         m_err [2][D];
  logic         m_wr  [2][D];
  int           ap;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] ref_exec(input opcode_t op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    longint sa, sb, r;
    logic   e;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 0;
    e  = 1'b0;
    case (op)
      ZERO:  r = 0;
      PASSA: r = sa;
      PASSB: r = sb;
      ADD:   r = sa + sb;
      SUB:   r = sa - sb;
      MULT:  r = sa * sb;
      DIV:   if (sb == 0) e = 1'b1; else r = sa / sb;
      MOD:   if (sb == 0) e = 1'b1; else r = sa % sb;
      default: r = 0;
    endcase
    return {e, r[W-1:0]};
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < D; i++) begin
        m_opc[k][i] = ZERO; m_a[k][i] = '0; m_b[k][i] = '0;
        m_r[k][i] = '0; m_err[k][i] = 1'b0; m_wr[k][i] = 1'b0;
      end
    ap = 0;
  endtask

  task automatic model_write(input opcode_t op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [AW-1:0] wp);
    logic [W:0] x;
    int idx;
    x = ref_exec(op, a, b);
    for (int k = 0; k < 2; k++) begin
      idx = (k == 0) ? int'(wp) : ap;
      m_opc[k][idx] = op;  m_a[k][idx] = a;  m_b[k][idx] = b;
      m_r[k][idx] = x[W-1:0]; m_err[k][idx] = x[W]; m_wr[k][idx] = 1'b1;
    end
    ap = (ap + 1) % D;
  endtask

  task automatic do_reset();
    // load_en/read_en held high to show reset wins over both
    @(negedge clk);
    reset = 1'b1; load_en = 1'b1; read_en = 1'b1; opcode = ADD; read_pointer = '0;
    @(posedge clk); #1;
    chk("ready_in_reset0", W'(ready0), 0);
    chk("ready_in_reset1", W'(ready1), 0);
    @(posedge clk); #1;
    chk("valid_in_reset", W'(v0), 0);
    chk("result_in_reset", rr0, 0);
    chk("written_in_reset", W'(rw1), 0);
    @(negedge clk);
    reset = 1'b0; load_en = 1'b0; read_en = 1'b0;
    model_clear();
    #1;
    chk("ready_after_reset0", W'(ready0), 1);
    chk("ready_after_reset1", W'(ready1), 1);
  endtask

  task automatic issue(input opcode_t op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [AW-1:0] wp);
    int low;
    @(negedge clk);
    chk("ready_before_load", W'(ready0 & ready1), 1);
    load_en = 1'b1; opcode = op; operand_a = a; operand_b = b; write_pointer = wp;
    @(posedge clk); #1;
    load_en = 1'b0;
    model_write(op, a, b, wp);
    if (op == DIV || op == MOD) begin
      low = 0;
      forever begin
        @(negedge clk);
        if (ready0 && ready1) break;
        low++;
        if (low > 200) break;
      end
      chk("div_ready_low_cycles", W'(low), W + 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic read_raw(input logic [AW-1:0] rp);
    @(negedge clk);
    read_en = 1'b1; read_pointer = rp;
    @(posedge clk); #1;
    read_en = 1'b0;
  endtask

  task automatic read_check(input logic [AW-1:0] rp);
    read_raw(rp);
    chk("rd_valid0", W'(v0), 1);
    chk("rd_opcode0", W'(ro0), W'(m_opc[0][rp]));
    chk("rd_operand_a0", ra0, m_a[0][rp]);
    chk("rd_operand_b0", rb0, m_b[0][rp]);
    chk("rd_result0", rr0, m_r[0][rp]);
    chk("rd_div_err0", W'(re0), W'(m_err[0][rp]));
    chk("rd_written0", W'(rw0), W'(m_wr[0][rp]));
    chk("rd_valid1", W'(v1), 1);
    chk("rd_opcode1", W'(ro1), W'(m_opc[1][rp]));
    chk("rd_operand_a1", ra1, m_a[1][rp]);
    chk("rd_operand_b1", rb1, m_b[1][rp]);
    chk("rd_result1", rr1, m_r[1][rp]);
    chk("rd_div_err1", W'(re1), W'(m_err[1][rp]));
    chk("rd_written1", W'(rw1), W'(m_wr[1][rp]));
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return W'($urandom_range(1, 40));
      4:       return -W'($urandom_range(1, 40));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; load_en = 1'b0; read_en = 1'b0; opcode = ZERO;
    operand_a = '0; operand_b = '0; write_pointer = '0; read_pointer = '0;
    model_clear();
    do_reset();

    // ADD, then an untouched entry
    issue(ADD, 32'd5, 32'd7, 5'd3);
    idle(1);
    read_check(5'd3);
    chk("add_result", rr0, 32'd12);
    chk("add_opcode", W'(ro0), W'(ADD));
    chk("add_written", W'(rw0), 1);
    read_check(5'd4);
    chk("unwritten_entry", W'(rw0), 0);

    // signed DIV/MOD
    issue(DIV, -32'sd17, 32'd5, 5'd1);
    issue(MOD, -32'sd17, 32'd5, 5'd2);
    read_check(5'd1);
    chk("div_neg17_5", rr0, 32'hFFFF_FFFD);
    read_check(5'd2);
    chk("mod_neg17_5", rr0, 32'hFFFF_FFFE);

    // divide boundaries and MULT wrap
    issue(DIV, 32'd9, 32'd0, 5'd8);
    read_check(5'd8);
    chk("div_by_zero_res", rr0, 0);
    chk("div_by_zero_err", W'(re0), 1);
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
    read_check(5'd9);
    chk("div_minint_res", rr0, 32'h8000_0000);
    chk("div_minint_err", W'(re0), 0);
    issue(MOD, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
    read_check(5'd10);
    chk("mod_minint_res", rr0, 0);
    issue(MULT, 32'h0001_0000, 32'h0001_0000, 5'd11);
    idle(1);
    read_check(5'd11);
    chk("mult_wrap", rr0, 0);

    // auto pointer wraps and overwrites
    do_reset();
    for (int i = 0; i <= 32; i++) issue(PASSA, W'(i), '0, AW'(i));
    idle(1);
    read_check(5'd0);
    chk("auto_entry0", rr1, 32'd32);
    read_check(5'd1);
    chk("auto_entry1", rr1, 32'd1);
    read_check(5'd31);
    chk("auto_entry31", rr1, 32'd31);

    // reset in the middle of a divide
    @(negedge clk);
    load_en = 1'b1; opcode = DIV; operand_a = 32'd1000; operand_b = 32'd3; write_pointer = 5'd5;
    @(posedge clk); #1;
    load_en = 1'b0;
    repeat (10) @(posedge clk);
    do_reset();
    issue(ADD, 32'd100, 32'hFFFF_FFF6, 5'd6);
    idle(40);
    read_check(5'd5);
    chk("aborted_div_written", W'(rw0), 0);
    read_check(5'd6);
    chk("add_after_abort", rr0, 32'd90);

    // same-edge read/write of one entry
    issue(PASSA, 32'h11, '0, 5'd7);
    idle(1);
    issue(PASSA, 32'hAA, '0, 5'd7);
    read_raw(5'd7);
    chk("same_edge_old", rr0, 32'h11);
    idle(1);
    read_check(5'd7);
    chk("after_write_new", rr0, 32'hAA);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      opcode_t op;
      op = opcode_t'($urandom_range(0, 7));
      issue(op, rnd_operand(), rnd_operand(), AW'($urandom_range(0, D - 1)));
    end
    idle(1);
    for (int r = 0; r < D; r++) read_check(AW'(r));
    idle(1);
    chk("valid_drops", W'(v0), 0);
    chk("rd_holds", rr0, m_r[0][D-1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
